mdu_hilo: RTL and testbench

- E-stage multiply/divide unit with the HI/LO architectural registers.
- Sits in parallel with the ALU and takes the same E-stage operands (rs value, and rt value or immediate) from the D/E pipeline register.
- Multi-cycle: a start pulse launches an operation, `busy` is asserted for a fixed latency, then the result commits to HI/LO.
- The hazard unit stalls D on `busy|start` whenever the D instruction is an MDU op.

---
 rtl/mdu_hilo.sv | 128 ++++++++++++
 tb/tb_mdu_hilo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// E-stage multiply/divide unit owning the HI/LO registers.
// Results are computed at launch into pending registers and committed after a fixed busy latency.
module mdu_hilo #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  mdu_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] count;
   logic [31:0] pend_hi;
   logic [31:0] pend_lo;
   logic        pend_write;

   logic        launch;
   logic        commit;
   logic        write_hi;
   logic        write_lo;

   logic        is_div;
   logic        is_signed;
   logic [63:0] product;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quot;
   logic [31:0] rem;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      launch     = 1'b0;
      commit     = 1'b0;
      write_hi   = 1'b0;
      write_lo   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               case (mdu_op)
                  3'b000, 3'b001, 3'b010, 3'b011: begin
                     launch     = 1'b1;
                     state_next = RUN;
                  end
                  3'b100:  write_hi = 1'b1;
                  3'b101:  write_lo = 1'b1;
                  default: ;
               endcase
            end
         end
         RUN: begin
            busy = 1'b1;
            if (count == '0) begin
               commit     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Sign handling is done on magnitudes so 0x80000000 / -1 wraps to 0x80000000
   // without relying on signed-division overflow behaviour.
   always_comb begin
      is_div    = mdu_op[1];
      is_signed = ~mdu_op[0];
      if (is_signed) product = {{32{A[31]}}, A} * {{32{B[31]}}, B};
      else           product = {32'd0, A} * {32'd0, B};
      a_neg = is_signed & A[31];
      b_neg = is_signed & B[31];
      a_mag = a_neg ? (32'd0 - A) : A;
      if (B == '0) b_mag = 32'd1;
      else         b_mag = b_neg ? (32'd0 - B) : B;
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
      quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      rem   = a_neg ? (32'd0 - r_mag) : r_mag;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count      <= '0;
         pend_hi    <= '0;
         pend_lo    <= '0;
         pend_write <= 1'b0;
         HI         <= '0;
         LO         <= '0;
      end else begin
         if (launch) begin
            count      <= is_div ? 32'(DIV_CYCLES - 1) : 32'(MUL_CYCLES - 1);
            pend_hi    <= is_div ? rem  : product[63:32];
            pend_lo    <= is_div ? quot : product[31:0];
            pend_write <= ~(is_div && (B == '0));
         end else if (state == RUN && count != '0) begin
            count <= count - 32'd1;
         end

         if (commit && pend_write) HI <= pend_hi;
         else if (write_hi)        HI <= A;

         if (commit && pend_write) LO <= pend_lo;
         else if (write_lo)        LO <= A;
      end
   end

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: stimulus queues expected HI/LO and busy length,
// a monitor pops and compares each time busy falls.
module tb_mdu_hilo;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  mdu_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int unsigned cycles;
   } exp_t;

   exp_t sb[$];

   mdu_hilo #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .mdu_op (mdu_op),
      .A      (a),
      .B      (b),
      .busy   (busy),
      .HI     (hi),
      .LO     (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: counts busy cycles and compares HI/LO when an operation commits.
   initial begin
      logic        prev;
      int unsigned cnt;
      exp_t        e;
      prev = 1'b0;
      cnt  = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev = 1'b0;
            cnt  = 0;
         end else begin
            if (busy) cnt++;
            else if (prev) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_commit: got commit expected none");
               end else begin
                  e = sb.pop_front();
                  check({e.name, "_busy"}, cnt, e.cycles);
                  check({e.name, "_hi"}, hi, e.hi);
                  check({e.name, "_lo"}, lo, e.lo);
               end
               cnt = 0;
            end
            prev = busy;
         end
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      check("idle_timeout", {31'd0, busy}, 32'd0);
      @(negedge clk);
   endtask

   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                         input int unsigned cyc);
      exp_t e;
      e.name = name; e.hi = ehi; e.lo = elo; e.cycles = cyc;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b1; mdu_op = op; a = av; b = bv;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
   endtask

   task automatic move(input logic [2:0] op, input logic [31:0] av);
      @(negedge clk);
      start = 1'b1; mdu_op = op; a = av;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; mdu_op = 3'b111; a = '0; b = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_hi", hi, 32'h0);
      check("reset_lo", lo, 32'h0);

      // MTHI then MTLO on consecutive edges
      @(negedge clk);
      start = 1'b1; mdu_op = 3'b100; a = 32'h12345678;
      @(negedge clk);
      check("mthi_hi", hi, 32'h12345678);
      check("mthi_lo", lo, 32'h0);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      mdu_op = 3'b101; a = 32'h9ABCDEF0;
      @(negedge clk);
      start = 1'b0;
      check("mtlo_hi", hi, 32'h12345678);
      check("mtlo_lo", lo, 32'h9ABCDEF0);
      check("mtlo_busy", {31'd0, busy}, 32'd0);

      // Undefined op: no change
      move(3'b110, 32'h11111111);
      check("noop_hi", hi, 32'h12345678);
      check("noop_lo", lo, 32'h9ABCDEF0);

      run_op("mult_neg",  3'b000, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
      run_op("multu",     3'b001, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA, 5);
      run_op("mult_min",  3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 5);
      run_op("div_neg",   3'b010, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      run_op("divu",      3'b011, 32'h7, 32'h2, 32'h1, 32'h3, 10);
      run_op("divu_big",  3'b011, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 10);
      run_op("div_negb",  3'b010, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 10);

      move(3'b100, 32'hAAAA0000);
      move(3'b101, 32'h00005555);
      run_op("div_zero",  3'b010, 32'h1234, 32'h0, 32'hAAAA0000, 32'h00005555, 10);
      run_op("divu_zero", 3'b011, 32'h1234, 32'h0, 32'hAAAA0000, 32'h00005555, 10);
      run_op("div_ovf",   3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10);

      // Start during RUN is ignored
      begin
         exp_t e;
         e.name = "multu_ign"; e.hi = 32'h0; e.lo = 32'hC; e.cycles = 5;
         sb.push_back(e);
         @(negedge clk);
         start = 1'b1; mdu_op = 3'b001; a = 32'd3; b = 32'd4;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
         start = 1'b1; mdu_op = 3'b101; a = 32'h0000DEAD;
         @(negedge clk);
         start = 1'b0;
         check("ign_lo_hold", lo, 32'h80000000);
         check("ign_busy", {31'd0, busy}, 32'd1);
         wait_idle();
      end

      // Asynchronous reset during busy cycle 4 of a DIV
      @(negedge clk);
      start = 1'b1; mdu_op = 3'b010; a = 32'd100; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);
      @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (12) @(negedge clk);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_hi", hi, 32'h0);
      check("post_rst_lo", lo, 32'h0);
      run_op("mult_after", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5);

      check("sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
